id_stage: RTL and testbench

Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of the fetch stage. Consumes the fetched PC/instruction pair, reads the 32×32 register file, and generates control signals and the sign/zero-extended immediate. Resolves beq/bne/j in decode and detects load-use and branch-operand hazards. All results are captured in the ID/EX pipeline register.

---
 rtl/mips_pkg.sv | 56 +++++
 rtl/register_file.sv | 56 +++++
 rtl/id_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_id_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg -- shared MIPS decode definitions.
//   Opcode / funct field values, the ALU-operation encoding, and the control
//   bundle carried from decode into EX (the EX stage imports the same struct).
//   No ports; imported with `import mips_pkg::*;`.
`timescale 1ns/1ps
package mips_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (inst[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_LUI = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/register_file.sv
// register_file -- 32 x 32-bit MIPS register file.
//   Two combinational read ports, one write port committed on posedge i_clk.
//   $0 always reads 0 and ignores writes. Async active-high reset clears all.
//   Build option ID_BYPASS_EN: a same-cycle write to the register being read
//   is forwarded to the read port (write-through); otherwise the read returns
//   the pre-write contents.
// Ports:
//   i_clk, i_rst             clock, async active-high reset
//   i_rs_addr / o_rs_data    read port A
//   i_rt_addr / o_rt_data    read port B
//   i_we, i_waddr, i_wdata   write port
`timescale 1ns/1ps
module register_file (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_rs_addr,
  input  logic [4:0]  i_rt_addr,
  output logic [31:0] o_rs_data,
  output logic [31:0] o_rt_data,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

`ifdef ID_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [31:0] r_mem [32];
  logic [4:0]  w_ra  [2];
  logic [31:0] w_rd  [2];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (i_we && i_waddr != 5'd0) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign w_ra[0] = i_rs_addr;
  assign w_ra[1] = i_rt_addr;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    // $0 check first so the bypass can never resurrect a write to $0.
    assign w_rd[p] = (w_ra[p] == 5'd0)                      ? 32'd0   :
                     (BYPASS && i_we && i_waddr == w_ra[p]) ? i_wdata :
                                                              r_mem[w_ra[p]];
  end

  assign o_rs_data = w_rd[0];
  assign o_rt_data = w_rd[1];

endmodule

// File: rtl/id_stage.sv
// id_stage -- MIPS 5-stage pipeline instruction-decode stage.
//   Decodes the IF/ID instruction, reads the register file, builds control
//   and immediate, resolves beq/bne/j, detects load-use and branch-operand
//   hazards, and captures everything in the ID/EX register every clock.
//   Build option ID_BYPASS_EN enables register-file write-through (see
//   register_file); it also feeds the branch compare.
// Ports:
//   clk, rst                      clock, async active-high reset
//   IFtoID_PC/_inst/_valid        decode slot from fetch
//   wb_reg_write/_dest/_data      writeback port into the register file
//   ex_mem_read/_reg_write/_dest  instruction currently in EX (hazards)
//   stall                         hold PC and IF/ID (combinational)
//   branch_taken/_target          beq/bne redirect (combinational)
//   jump/jump_target              j redirect (combinational)
//   IDtoEX_*                      registered ID/EX pipeline contents
`timescale 1ns/1ps
module id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IFtoID_PC,
  input  logic [31:0] IFtoID_inst,
  input  logic        IFtoID_valid,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_dest,
  output logic        stall,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        jump,
  output logic [31:0] jump_target,
  output logic        IDtoEX_valid,
  output logic [31:0] IDtoEX_PC,
  output logic [31:0] IDtoEX_rs_data,
  output logic [31:0] IDtoEX_rt_data,
  output logic [31:0] IDtoEX_imm,
  output logic [4:0]  IDtoEX_rs,
  output logic [4:0]  IDtoEX_rt,
  output logic [4:0]  IDtoEX_dest,
  output logic [4:0]  IDtoEX_shamt,
  output logic        IDtoEX_reg_write,
  output logic        IDtoEX_mem_read,
  output logic        IDtoEX_mem_write,
  output logic        IDtoEX_mem_to_reg,
  output logic        IDtoEX_alu_src,
  output logic [3:0]  IDtoEX_alu_op,
  output logic        IDtoEX_illegal
);

  // instruction fields
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm16;

  assign w_op    = IFtoID_inst[31:26];
  assign w_rs    = IFtoID_inst[25:21];
  assign w_rt    = IFtoID_inst[20:16];
  assign w_rd    = IFtoID_inst[15:11];
  assign w_shamt = IFtoID_inst[10:6];
  assign w_funct = IFtoID_inst[5:0];
  assign w_imm16 = IFtoID_inst[15:0];

  logic [31:0] w_rs_data, w_rt_data;

  register_file u_rf (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_rs_addr (w_rs),
    .i_rt_addr (w_rt),
    .o_rs_data (w_rs_data),
    .o_rt_data (w_rt_data),
    .i_we      (wb_reg_write),
    .i_waddr   (wb_dest),
    .i_wdata   (wb_data)
  );

  // ---------------- decode ----------------
  ctrl_t       w_ctrl;
  logic [4:0]  w_dest;
  logic [31:0] w_imm;
  logic        w_illegal, w_rt_src, w_is_beq, w_is_bne, w_is_j;

  always_comb begin
    w_ctrl    = CTRL_NOP;
    w_dest    = 5'd0;
    w_imm     = sext16(w_imm16);
    w_illegal = 1'b0;
    w_rt_src  = 1'b0;   // rt is read as a source operand (load-use on rt)
    w_is_beq  = 1'b0;
    w_is_bne  = 1'b0;
    w_is_j    = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_dest           = w_rd;
        w_rt_src         = 1'b1;
        w_ctrl.reg_write = 1'b1;
        case (w_funct)
          FN_ADD:  w_ctrl.alu_op = ALU_ADD;
          FN_SUB:  w_ctrl.alu_op = ALU_SUB;
          FN_AND:  w_ctrl.alu_op = ALU_AND;
          FN_OR:   w_ctrl.alu_op = ALU_OR;
          FN_SLT:  w_ctrl.alu_op = ALU_SLT;
          FN_SLL:  w_ctrl.alu_op = ALU_SLL;
          FN_SRL:  w_ctrl.alu_op = ALU_SRL;
          default: begin
            w_ctrl    = CTRL_NOP;
            w_dest    = 5'd0;
            w_rt_src  = 1'b0;
            w_illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        w_dest           = w_rt;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        case (w_op)
          OP_SLTI: w_ctrl.alu_op = ALU_SLT;
          OP_ANDI: begin w_ctrl.alu_op = ALU_AND; w_imm = {16'h0, w_imm16}; end
          OP_ORI:  begin w_ctrl.alu_op = ALU_OR;  w_imm = {16'h0, w_imm16}; end
          OP_LUI:  begin w_ctrl.alu_op = ALU_LUI; w_imm = {w_imm16, 16'h0}; end
          default: w_ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        w_dest            = w_rt;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        w_rt_src         = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin w_is_beq = 1'b1; w_rt_src = 1'b1; end
      OP_BNE: begin w_is_bne = 1'b1; w_rt_src = 1'b1; end
      OP_J:   w_is_j = 1'b1;
      default: w_illegal = 1'b1;
    endcase
  end

  // ---------------- hazards / redirect ----------------
  logic [31:0] w_pc4;
  logic        w_load_use, w_br_hz, w_issue, w_eq;

  assign w_pc4 = IFtoID_PC + 32'd4;
  assign w_eq  = (w_rs_data == w_rt_data);

  assign w_load_use = ex_mem_read && ex_dest != 5'd0 &&
                      (ex_dest == w_rs || (w_rt_src && ex_dest == w_rt));
  // Branch compares in ID, so any in-flight producer of its operands must drain.
  assign w_br_hz    = (w_is_beq || w_is_bne) && ex_reg_write && ex_dest != 5'd0 &&
                      (ex_dest == w_rs || ex_dest == w_rt);

  assign stall   = IFtoID_valid && (w_load_use || w_br_hz);
  assign w_issue = IFtoID_valid && !stall;

  assign branch_taken  = w_issue && ((w_is_beq && w_eq) || (w_is_bne && !w_eq));
  assign branch_target = w_pc4 + (w_imm << 2);
  assign jump          = w_issue && w_is_j;
  assign jump_target   = {w_pc4[31:28], IFtoID_inst[25:0], 2'b00};

  // ---------------- ID/EX register ----------------
  logic        r_valid, r_illegal;
  ctrl_t       r_ctrl;
  logic [31:0] r_pc, r_rs_data, r_rt_data, r_imm;
  logic [4:0]  r_rs, r_rt, r_dest, r_shamt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_ctrl    <= CTRL_NOP;
      r_pc      <= RESET_PC;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_dest    <= '0;
      r_shamt   <= '0;
    end else begin
      // Stalls and empty slots become bubbles; datapath is loaded regardless.
      r_valid   <= w_issue;
      r_illegal <= w_issue && w_illegal;
      r_ctrl    <= w_issue ? w_ctrl : CTRL_NOP;
      r_pc      <= IFtoID_PC;
      r_rs_data <= w_rs_data;
      r_rt_data <= w_rt_data;
      r_imm     <= w_imm;
      r_rs      <= w_rs;
      r_rt      <= w_rt;
      r_dest    <= w_dest;
      r_shamt   <= w_shamt;
    end
  end

  assign IDtoEX_valid      = r_valid;
  assign IDtoEX_PC         = r_pc;
  assign IDtoEX_rs_data    = r_rs_data;
  assign IDtoEX_rt_data    = r_rt_data;
  assign IDtoEX_imm        = r_imm;
  assign IDtoEX_rs         = r_rs;
  assign IDtoEX_rt         = r_rt;
  assign IDtoEX_dest       = r_dest;
  assign IDtoEX_shamt      = r_shamt;
  assign IDtoEX_reg_write  = r_ctrl.reg_write;
  assign IDtoEX_mem_read   = r_ctrl.mem_read;
  assign IDtoEX_mem_write  = r_ctrl.mem_write;
  assign IDtoEX_mem_to_reg = r_ctrl.mem_to_reg;
  assign IDtoEX_alu_src    = r_ctrl.alu_src;
  assign IDtoEX_alu_op     = r_ctrl.alu_op;
  assign IDtoEX_illegal    = r_illegal;

endmodule

// File: tb/tb_id_stage.sv
`timescale 1ns/1ps
module tb_id_stage;
  import mips_pkg::*;

  localparam logic [31:0] RPC = 32'hBFC0_0000;
`ifdef ID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  // control packing {reg_write, mem_read, mem_write, mem_to_reg, alu_src}
  localparam logic [4:0] C_0 = 5'b00000, C_R = 5'b10000, C_I = 5'b10001,
                         C_LW = 5'b11011, C_SW = 5'b00101;

  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] IFtoID_PC, IFtoID_inst, wb_data;
  logic        IFtoID_valid, wb_reg_write, ex_mem_read, ex_reg_write;
  logic [4:0]  wb_dest, ex_dest;
  logic        stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic        IDtoEX_valid, IDtoEX_reg_write, IDtoEX_mem_read, IDtoEX_mem_write;
  logic        IDtoEX_mem_to_reg, IDtoEX_alu_src, IDtoEX_illegal;
  logic [31:0] IDtoEX_PC, IDtoEX_rs_data, IDtoEX_rt_data, IDtoEX_imm;
  logic [4:0]  IDtoEX_rs, IDtoEX_rt, IDtoEX_dest, IDtoEX_shamt;
  logic [3:0]  IDtoEX_alu_op;

  always #5 clk = ~clk;

  id_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .IFtoID_PC(IFtoID_PC), .IFtoID_inst(IFtoID_inst), .IFtoID_valid(IFtoID_valid),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_dest(ex_dest),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .IDtoEX_valid(IDtoEX_valid), .IDtoEX_PC(IDtoEX_PC),
    .IDtoEX_rs_data(IDtoEX_rs_data), .IDtoEX_rt_data(IDtoEX_rt_data),
    .IDtoEX_imm(IDtoEX_imm), .IDtoEX_rs(IDtoEX_rs), .IDtoEX_rt(IDtoEX_rt),
    .IDtoEX_dest(IDtoEX_dest), .IDtoEX_shamt(IDtoEX_shamt),
    .IDtoEX_reg_write(IDtoEX_reg_write), .IDtoEX_mem_read(IDtoEX_mem_read),
    .IDtoEX_mem_write(IDtoEX_mem_write), .IDtoEX_mem_to_reg(IDtoEX_mem_to_reg),
    .IDtoEX_alu_src(IDtoEX_alu_src), .IDtoEX_alu_op(IDtoEX_alu_op),
    .IDtoEX_illegal(IDtoEX_illegal)
  );

  typedef struct {
    int          tag;
    string       nm;
    logic        cd;                 // check datapath fields
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, dest, sh;
    logic        v;
    logic [4:0]  ctl;
    logic [3:0]  op;
    logic        ill;
    logic        st, br, jp, cbt, cjt;
    logic [31:0] bt, jt;
  } exp_t;

  int   nvec = 0, nfail = 0, cyc = 0;
  exp_t qc[$], qr[$];
  exp_t m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: combinational outputs are checked in the issue cycle, the ID/EX
  // contents one clock later.
  always @(negedge clk) begin
    if (!rst) begin
      while (qr.size() > 0 && qr[0].tag < cyc) begin
        m = qr.pop_front();
        chk({m.nm, ".valid"}, IDtoEX_valid, m.v);
        chk({m.nm, ".ctl"}, {IDtoEX_reg_write, IDtoEX_mem_read, IDtoEX_mem_write,
                             IDtoEX_mem_to_reg, IDtoEX_alu_src}, m.ctl);
        chk({m.nm, ".alu_op"}, IDtoEX_alu_op, m.op);
        chk({m.nm, ".illegal"}, IDtoEX_illegal, m.ill);
        if (m.cd) begin
          chk({m.nm, ".pc"}, IDtoEX_PC, m.pc);
          chk({m.nm, ".rs_data"}, IDtoEX_rs_data, m.rsd);
          chk({m.nm, ".rt_data"}, IDtoEX_rt_data, m.rtd);
          chk({m.nm, ".imm"}, IDtoEX_imm, m.imm);
          chk({m.nm, ".rs_rt"}, {IDtoEX_rs, IDtoEX_rt}, {m.rs, m.rt});
          chk({m.nm, ".dest"}, IDtoEX_dest, m.dest);
          chk({m.nm, ".shamt"}, IDtoEX_shamt, m.sh);
        end
      end
      while (qc.size() > 0 && qc[0].tag <= cyc) begin
        m = qc.pop_front();
        chk({m.nm, ".stall"}, stall, m.st);
        chk({m.nm, ".branch_taken"}, branch_taken, m.br);
        chk({m.nm, ".jump"}, jump, m.jp);
        if (m.cbt) chk({m.nm, ".branch_target"}, branch_target, m.bt);
        if (m.cjt) chk({m.nm, ".jump_target"}, jump_target, m.jt);
      end
    end
  end

  function automatic exp_t bub(input string nm);
    exp_t e;
    e.tag = 0; e.nm = nm; e.cd = 1'b0;
    e.pc = '0; e.rsd = '0; e.rtd = '0; e.imm = '0;
    e.rs = '0; e.rt = '0; e.dest = '0; e.sh = '0;
    e.v = 1'b0; e.ctl = C_0; e.op = 4'd0; e.ill = 1'b0;
    e.st = 1'b0; e.br = 1'b0; e.jp = 1'b0; e.cbt = 1'b0; e.cjt = 1'b0;
    e.bt = '0; e.jt = '0;
    return e;
  endfunction

  function automatic exp_t ins(input string nm, input logic [31:0] pc, rsd, rtd, imm,
                               input logic [4:0] rs, rt, dest, sh,
                               input logic [4:0] ctl, input logic [3:0] op);
    exp_t e;
    e = bub(nm);
    e.cd = 1'b1; e.v = 1'b1;
    e.pc = pc; e.rsd = rsd; e.rtd = rtd; e.imm = imm;
    e.rs = rs; e.rt = rt; e.dest = dest; e.sh = sh; e.ctl = ctl; e.op = op;
    return e;
  endfunction

  task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    IFtoID_valid = v; IFtoID_PC = pc; IFtoID_inst = inst;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dest = 5'd0;
    wb_reg_write = 1'b0; wb_dest = 5'd0; wb_data = 32'd0;
  endtask

  task automatic wb(input logic [4:0] d, input logic [31:0] data);
    wb_reg_write = 1'b1; wb_dest = d; wb_data = data;
  endtask

  task automatic step(input exp_t e);
    e.tag = cyc;
    qc.push_back(e);
    qr.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic rst_chk(input string nm);
    chk({nm, ".valid"}, IDtoEX_valid, 1'b0);
    chk({nm, ".pc"}, IDtoEX_PC, RPC);
    chk({nm, ".ctl"}, {IDtoEX_reg_write, IDtoEX_mem_read, IDtoEX_mem_write,
                       IDtoEX_mem_to_reg, IDtoEX_alu_src, IDtoEX_alu_op, IDtoEX_illegal}, 32'd0);
    chk({nm, ".data"}, IDtoEX_rs_data | IDtoEX_rt_data | IDtoEX_imm, 32'd0);
    chk({nm, ".fields"}, {IDtoEX_rs, IDtoEX_rt, IDtoEX_dest, IDtoEX_shamt}, 32'd0);
  endtask

  exp_t e;

  initial begin
    drv(1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_chk("rst");
    rst = 1'b0;

    // write $5, read it back, then reset mid-operation
    drv(0, 0, 0); wb(5, 32'h1234); step(bub("wb5"));
    drv(1, 32'h8, 32'h00A54820);
    step(ins("add9_55", 32'h8, 32'h1234, 32'h1234, 32'h4820, 5, 5, 9, 0, C_R, ALU_ADD));
    drv(0, 0, 0);
    @(negedge clk); #1;
    rst = 1'b1; wb(5, 32'h77);      // writeback during reset is lost
    #1;
    rst_chk("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    drv(1, 32'hC, 32'h00A54820);
    step(ins("add9_rst", 32'hC, 0, 0, 32'h4820, 5, 5, 9, 0, C_R, ALU_ADD));

    drv(0, 0, 0); wb(1, 32'd7);    step(bub("wb1"));
    drv(0, 0, 0); wb(3, 32'h10);   step(bub("wb3"));

    drv(1, 32'h10, 32'h2002FFFF);
    step(ins("addi", 32'h10, 0, 0, 32'hFFFF_FFFF, 0, 2, 2, 5'h1F, C_I, ALU_ADD));

    // load-use
    drv(1, 32'h14, 32'h00612020); ex_mem_read = 1; ex_dest = 3;
    e = bub("lu_rs"); e.st = 1; step(e);
    drv(1, 32'h14, 32'h00612020);
    step(ins("lu_pass", 32'h14, 32'h10, 7, 32'h2020, 3, 1, 4, 0, C_R, ALU_ADD));
    drv(1, 32'h18, 32'h00612020); ex_mem_read = 1; ex_dest = 1;
    e = bub("lu_rt"); e.st = 1; step(e);
    drv(1, 32'h1C, 32'h20250001); ex_mem_read = 1; ex_dest = 5;
    step(ins("lu_nort", 32'h1C, 7, 0, 32'h1, 1, 5, 5, 0, C_I, ALU_ADD));
    drv(0, 32'h14, 32'h00612020); ex_mem_read = 1; ex_dest = 3;
    step(bub("lu_nv"));
    drv(1, 32'h24, 32'h00612020); ex_reg_write = 1; ex_dest = 3;
    step(ins("exw_add", 32'h24, 32'h10, 7, 32'h2020, 3, 1, 4, 0, C_R, ALU_ADD));

    // branches / jump
    drv(1, 32'h20, 32'h10210004); ex_reg_write = 1; ex_dest = 1;
    e = bub("br_hz"); e.st = 1; step(e);
    drv(1, 32'h20, 32'h10210004);
    e = ins("beq", 32'h20, 7, 7, 32'h4, 1, 1, 0, 0, C_0, ALU_ADD);
    e.br = 1; e.cbt = 1; e.bt = 32'h34; step(e);
    drv(1, 32'h20, 32'h14210004);
    e = ins("bne_eq", 32'h20, 7, 7, 32'h4, 1, 1, 0, 0, C_0, ALU_ADD);
    e.cbt = 1; e.bt = 32'h34; step(e);
    drv(1, 32'h40, 32'h1423FFFF);
    e = ins("bne_ne", 32'h40, 7, 32'h10, 32'hFFFF_FFFF, 1, 3, 0, 5'h1F, C_0, ALU_ADD);
    e.br = 1; e.cbt = 1; e.bt = 32'h40; step(e);
    drv(1, 32'h1000_0000, 32'h08000040);
    e = ins("j", 32'h1000_0000, 0, 0, 32'h40, 0, 0, 0, 1, C_0, ALU_ADD);
    e.jp = 1; e.cjt = 1; e.jt = 32'h1000_0100; step(e);
    drv(0, 32'h1000_0000, 32'h08000040);
    e = bub("j_nv"); e.cjt = 1; e.jt = 32'h1000_0100; step(e);

    // illegal
    drv(1, 32'h30, 32'hFC000000);
    e = ins("ill_op", 32'h30, 0, 0, 0, 0, 0, 0, 0, C_0, ALU_ADD); e.ill = 1; e.cd = 0; step(e);
    drv(1, 32'h34, 32'h0061203F);
    e = ins("ill_fn", 32'h34, 0, 0, 0, 0, 0, 0, 0, C_0, ALU_ADD); e.ill = 1; e.cd = 0; step(e);

    // decode table
    drv(1, 32'h50, 32'h8C2A0008);
    step(ins("lw",   32'h50, 7, 0, 32'h8, 1, 10, 10, 0, C_LW, ALU_ADD));
    drv(1, 32'h54, 32'hAC23FFFC);
    step(ins("sw",   32'h54, 7, 32'h10, 32'hFFFF_FFFC, 1, 3, 0, 5'h1F, C_SW, ALU_ADD));
    drv(1, 32'h58, 32'h342B8000);
    step(ins("ori",  32'h58, 7, 0, 32'h0000_8000, 1, 11, 11, 0, C_I, ALU_OR));
    drv(1, 32'h5C, 32'h3C0C1234);
    step(ins("lui",  32'h5C, 0, 0, 32'h1234_0000, 0, 12, 12, 8, C_I, ALU_LUI));
    drv(1, 32'h60, 32'h302DFFFF);
    step(ins("andi", 32'h60, 7, 0, 32'h0000_FFFF, 1, 13, 13, 5'h1F, C_I, ALU_AND));
    drv(1, 32'h64, 32'h282EFFFE);
    step(ins("slti", 32'h64, 7, 0, 32'hFFFF_FFFE, 1, 14, 14, 5'h1F, C_I, ALU_SLT));
    drv(1, 32'h68, 32'h000178C0);
    step(ins("sll",  32'h68, 0, 7, 32'h78C0, 0, 1, 15, 3, C_R, ALU_SLL));
    drv(1, 32'h6C, 32'h000178C2);
    step(ins("srl",  32'h6C, 0, 7, 32'h78C2, 0, 1, 15, 3, C_R, ALU_SRL));
    drv(1, 32'h70, 32'h00618022);
    step(ins("sub",  32'h70, 32'h10, 7, 32'hFFFF_8022, 3, 1, 16, 0, C_R, ALU_SUB));
    drv(1, 32'h74, 32'h0061882A);
    step(ins("slt",  32'h74, 32'h10, 7, 32'hFFFF_882A, 3, 1, 17, 0, C_R, ALU_SLT));
    drv(1, 32'h78, 32'h00619024);
    step(ins("and",  32'h78, 32'h10, 7, 32'hFFFF_9024, 3, 1, 18, 0, C_R, ALU_AND));
    drv(1, 32'h7C, 32'h00619825);
    step(ins("or",   32'h7C, 32'h10, 7, 32'hFFFF_9825, 3, 1, 19, 0, C_R, ALU_OR));

    // same-cycle writeback / $0 rule
    drv(1, 32'h80, 32'h00C03825); wb(6, 32'hAB);
    step(ins("byp_or", 32'h80, BYP ? 32'hAB : 32'h0, 0, 32'h3825, 6, 0, 7, 0, C_R, ALU_OR));
    drv(1, 32'h84, 32'h00C03825);
    step(ins("after_wb6", 32'h84, 32'hAB, 0, 32'h3825, 6, 0, 7, 0, C_R, ALU_OR));
    drv(1, 32'h88, 32'h00003825); wb(0, 32'h55);
    step(ins("wr0_same", 32'h88, 0, 0, 32'h3825, 0, 0, 7, 0, C_R, ALU_OR));
    drv(1, 32'h88, 32'h00003825);
    step(ins("wr0_after", 32'h88, 0, 0, 32'h3825, 0, 0, 7, 0, C_R, ALU_OR));
    drv(1, 32'h8C, 32'h10D40001); wb(20, 32'hAB);
    e = ins("beq_byp", 32'h8C, 32'hAB, BYP ? 32'hAB : 32'h0, 32'h1, 6, 20, 0, 0, C_0, ALU_ADD);
    e.br = BYP; e.cbt = 1; e.bt = 32'h94; step(e);

    drv(0, 0, 0);
    step(bub("tail"));

    for (int i = 0; i < 10 && (qr.size() > 0 || qc.size() > 0); i++) @(posedge clk);
    #1;
    if (qr.size() > 0 || qc.size() > 0) begin
      nfail++;
      $display("FAIL drain: %0d entries left, expected 0", qr.size() + qc.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
